// File: rtl/sync_debounce_filter_if.sv
// sync_debounce_filter_if
//   Groups the data-path signals of one sync_debounce_filter instance.
//   master drives the raw inputs and observes the filtered outputs;
//   slave is the filter side.
//   data   raw synchronized inputs
//   level  filtered level
//   rise   rising-edge strobes
//   fall   falling-edge strobes
//   busy   change-pending flags

interface sync_debounce_filter_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] data;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] busy;

  modport master (output data, input level, rise, fall, busy);
  modport slave  (input data, output level, rise, fall, busy);
endinterface

// File: rtl/sync_debounce_filter.sv
// sync_debounce_filter
//   Per-channel stability filter for inputs that are already synchronized
//   into the local clock domain. A channel's filtered level moves only after
//   the input has disagreed with it for STABLE_CYCLES consecutive enabled
//   samples. Each accepted change emits a one-cycle rise or fall strobe.
//
// Ports
//   sys_dom_i  clock-domain bundle: .clk (posedge), .sync_rst (sync, active
//              high, wins over enable), .clk_en (advance enable)
//   data_i     synchronized raw inputs, one bit per channel
//   level_o    filtered level, registered
//   rise_o     1-cycle strobe, level_o[n] went 0->1 at this edge
//   fall_o     1-cycle strobe, level_o[n] went 1->0 at this edge
//   busy_o     channel has a change pending (counter non-zero)

package sys_structs;
  typedef struct packed {
    logic clk;
    logic sync_rst;
    logic clk_en;
  } clk_domain;
endpackage

// One channel: disagreement counter plus registered level and strobes.
module sync_debounce_lane #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  localparam int unsigned CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  // Counter value at which the next disagreeing sample is accepted.
  localparam logic [CW-1:0] LAST = CW'((STABLE_CYCLES < 1) ? 0 : STABLE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;   // strobes drop on any edge that does not accept
    fall_d = 1'b0;
    if (en) begin
      if (data_i == lvl_q) begin
        cnt_d = '0;  // any agreeing sample cancels a pending change
      end else if (cnt_q == LAST) begin
        lvl_d  = data_i;
        cnt_d  = '0;
        rise_d = data_i;
        fall_d = ~data_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lvl_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = (cnt_q != '0);
endmodule

module sync_debounce_filter #(
  parameter int unsigned              CHANNEL_WIDTH = 4,
  parameter int unsigned              STABLE_CYCLES = 8,
  parameter logic [CHANNEL_WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  sys_structs::clk_domain    sys_dom_i,
  input  logic [CHANNEL_WIDTH-1:0]  data_i,
  output logic [CHANNEL_WIDTH-1:0]  level_o,
  output logic [CHANNEL_WIDTH-1:0]  rise_o,
  output logic [CHANNEL_WIDTH-1:0]  fall_o,
  output logic [CHANNEL_WIDTH-1:0]  busy_o
);
  if (STABLE_CYCLES < 1) begin : g_bad_param
    $error("sync_debounce_filter: STABLE_CYCLES must be >= 1");
  end

  logic clk, rst, en;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.sync_rst;
  assign en  = sys_dom_i.clk_en;

  for (genvar n = 0; n < CHANNEL_WIDTH; n++) begin : g_lane
    sync_debounce_lane #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_LEVEL[n])
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .data_i  (data_i[n]),
      .level_o (level_o[n]),
      .rise_o  (rise_o[n]),
      .fall_o  (fall_o[n]),
      .busy_o  (busy_o[n])
    );
  end
endmodule

// File: tb/tb_sync_debounce_filter.sv
// Bench for sync_debounce_filter.
//   DUT A: STABLE_CYCLES=8, RESET_LEVEL=0000 -- hand sequences and random
//          traffic compared every cycle to a sample-history reference model.
//   DUT B: STABLE_CYCLES=1, RESET_LEVEL=0101 -- table of vectors.
module tb_sync_debounce_filter;
  localparam int          W   = 4;
  localparam int          SA  = 8;
  localparam logic [W-1:0] RLA = 4'b0000;
  localparam logic [W-1:0] RLB = 4'b0101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b1;
  logic rst_b = 1'b1, en_b = 1'b1;

  sync_debounce_filter_if #(.W(W)) ifa ();
  sync_debounce_filter_if #(.W(W)) ifb ();

  sys_structs::clk_domain dom_a, dom_b;
  always_comb begin
    dom_a.clk = clk; dom_a.sync_rst = rst_a; dom_a.clk_en = en_a;
    dom_b.clk = clk; dom_b.sync_rst = rst_b; dom_b.clk_en = en_b;
  end

  sync_debounce_filter #(.CHANNEL_WIDTH(W), .STABLE_CYCLES(SA), .RESET_LEVEL(RLA)) u_dut_a (
    .sys_dom_i (dom_a),
    .data_i    (ifa.data),
    .level_o   (ifa.level),
    .rise_o    (ifa.rise),
    .fall_o    (ifa.fall),
    .busy_o    (ifa.busy)
  );

  sync_debounce_filter #(.CHANNEL_WIDTH(W), .STABLE_CYCLES(1), .RESET_LEVEL(RLB)) u_dut_b (
    .sys_dom_i (dom_b),
    .data_i    (ifb.data),
    .level_o   (ifb.level),
    .rise_o    (ifb.rise),
    .fall_o    (ifb.fall),
    .busy_o    (ifb.busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for DUT A: keeps the recent enabled samples of each
  // channel and accepts a change once the newest SA samples all disagree
  // with the current level.
  logic [W-1:0] m_lvl, m_rise, m_fall, m_busy;
  bit           hq [W][$];
  bit           m_started = 1'b0;

  task automatic model_step();
    m_rise = '0;
    m_fall = '0;
    if (rst_a) begin
      m_lvl  = RLA;
      m_busy = '0;
      for (int n = 0; n < W; n++) hq[n].delete();
    end else if (en_a) begin
      for (int n = 0; n < W; n++) begin
        int run;
        hq[n].push_back(ifa.data[n]);
        while (hq[n].size() > SA) void'(hq[n].pop_front());
        run = 0;
        for (int i = hq[n].size() - 1; i >= 0; i--) begin
          if (hq[n][i] != m_lvl[n]) run++;
          else break;
        end
        if (run == SA) begin
          if (ifa.data[n]) m_rise[n] = 1'b1;
          else             m_fall[n] = 1'b1;
          m_lvl[n] = ifa.data[n];
          hq[n].delete();
        end
        m_busy[n] = (hq[n].size() > 0) && (hq[n][hq[n].size()-1] != m_lvl[n]);
      end
    end
    m_started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("model_level", ifa.level, m_lvl);
      chk("model_rise",  ifa.rise,  m_rise);
      chk("model_fall",  ifa.fall,  m_fall);
      chk("model_busy",  ifa.busy,  m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [W-1:0] lvl;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl [10];

  initial begin
    ifa.data = '0;
    ifb.data = '0;

    // DUT B vectors (STABLE_CYCLES=1, RESET_LEVEL=0101); busy must stay 0.
    tbl[0] = '{1'b1, 1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
    tbl[1] = '{1'b1, 1'b0, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
    tbl[2] = '{1'b0, 1'b1, 4'b0011, 4'b0011, 4'b0010, 4'b0100};
    tbl[3] = '{1'b0, 1'b1, 4'b1100, 4'b1100, 4'b1100, 4'b0011};
    tbl[4] = '{1'b0, 1'b1, 4'b1100, 4'b1100, 4'b0000, 4'b0000};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 4'b1100, 4'b0000, 4'b0000};
    tbl[6] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    tbl[7] = '{1'b1, 1'b1, 4'b1010, 4'b0101, 4'b0000, 4'b0000};
    tbl[8] = '{1'b0, 1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b0101};
    tbl[9] = '{1'b0, 1'b0, 4'b0101, 4'b1010, 4'b0000, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      rst_b    = tbl[i].rst;
      en_b     = tbl[i].en;
      ifb.data = tbl[i].d;
      tick();
      chk($sformatf("vecB%0d_level", i), ifb.level, tbl[i].lvl);
      chk($sformatf("vecB%0d_rise",  i), ifb.rise,  tbl[i].rise);
      chk($sformatf("vecB%0d_fall",  i), ifb.fall,  tbl[i].fall);
      chk($sformatf("vecB%0d_busy",  i), ifb.busy,  4'b0000);
    end

    // DUT A has been in reset throughout the table.
    chk("a_reset_level", ifa.level, RLA);
    chk("a_reset_busy",  ifa.busy,  4'b0000);

    // Accept: bit0 steady high, change lands on the 8th enabled edge.
    rst_a = 1'b0; en_a = 1'b1; ifa.data = 4'b0001;
    for (int i = 0; i < SA; i++) begin
      tick();
      if (i < SA - 1) begin
        chk("accept_level_hold", ifa.level, 4'b0000);
        chk("accept_busy",       ifa.busy,  4'b0001);
        chk("accept_rise_early", ifa.rise,  4'b0000);
      end else begin
        chk("accept_level", ifa.level, 4'b0001);
        chk("accept_rise",  ifa.rise,  4'b0001);
        chk("accept_busy0", ifa.busy,  4'b0000);
      end
    end
    tick();
    chk("accept_rise_clear", ifa.rise,  4'b0000);
    chk("accept_level_keep", ifa.level, 4'b0001);

    // Glitch: bit1 high for 7 samples, then back low.
    ifa.data = 4'b0011;
    for (int i = 0; i < SA - 1; i++) begin
      tick();
      chk("glitch_busy",  ifa.busy,  4'b0010);
      chk("glitch_level", ifa.level, 4'b0001);
    end
    ifa.data = 4'b0001;
    tick();
    chk("glitch_busy0", ifa.busy,  4'b0000);
    chk("glitch_level", ifa.level, 4'b0001);
    chk("glitch_rise",  ifa.rise,  4'b0000);

    // Enable gap: bit2 step, 4 enabled samples, 3 disabled, then 4 more.
    ifa.data = 4'b0101;
    for (int i = 0; i < 4; i++) tick();
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_busy",  ifa.busy,  4'b0100);
      chk("gap_level", ifa.level, 4'b0001);
      chk("gap_rise",  ifa.rise,  4'b0000);
    end
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_post_level", ifa.level, 4'b0001);
    end
    tick();
    chk("gap_flip_level", ifa.level, 4'b0101);
    chk("gap_flip_rise",  ifa.rise,  4'b0100);
    tick();
    chk("gap_rise_clear", ifa.rise,  4'b0000);

    // Reset mid-count: bit2 pending fall discarded, no strobe.
    ifa.data = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_busy_pre", ifa.busy, 4'b0100);
    rst_a = 1'b1;
    tick();
    chk("midrst_level", ifa.level, 4'b0000);
    chk("midrst_fall",  ifa.fall,  4'b0000);
    chk("midrst_busy",  ifa.busy,  4'b0000);
    rst_a = 1'b0; ifa.data = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("postrst_level", ifa.level, 4'b0000);
      chk("postrst_busy",  ifa.busy,  4'b0000);
      chk("postrst_fall",  ifa.fall,  4'b0000);
    end

    // Random traffic: slow-moving inputs (mostly accepted) then fast bounce.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 1500; c++) begin
        rst_a = ($urandom_range(0, 199) == 0);
        en_a  = ($urandom_range(0, 9) != 0);
        for (int n = 0; n < W; n++)
          if ($urandom_range(0, (ph == 0) ? 13 : 3) == 0) ifa.data[n] = ~ifa.data[n];
        tick();
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
